mc_control_unit_hs: RTL and testbench
=====================================

Name: mc_control_unit_hs

Overview:
- Next-generation multicycle MIPS control unit. It replaces the fixed-timing controller with a handshaked FSM that tolerates variable memory latency.
- Adds bne, addi and j support, a wait-state timeout, and an illegal-instruction halt.
- Sits between the instruction register and the datapath/memory. It drives all datapath select and enable strobes, plus a combined PC enable.

Parameters:
- TIMEOUT, 16, maximum wait cycles for mem_ready in any memory state; 0 disables the timeout.
- TO_W, 5, width of the wait counter; must satisfy 2^TO_W > TIMEOUT.
- CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Opcode  in  6  instr[31:26]
- Funct  in  6  instr[5:0]
- ZeroFlag  in  1  ALU zero result
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  write qualifier, held with mem_req
- IorD  out  1  0=PC, 1=ALUOut address
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register-file write data = memory data
- RegDst  out  1  1=rd, 0=rt
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=const 4, 10=signimm, 11=signimm<<2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- PCEn  out  1  PC register enable
- halted  out  1  sticky halt indicator
- err_code  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout
- retired  out  CNT_W  retired count (only with PERF_CNT_EN)

Behaviour:
- Reset (asynchronous) forces state FETCH, wait counter 0, halted 0, err_code 00.
  - Outputs in reset therefore equal the FETCH decode: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00. All other strobes are 0.
  - Reset mid-access abandons the access with no completion.
- States and outputs; outputs are Moore except strobes marked "&rdy", which are asserted only when mem_ready=1 in that cycle:
  - FETCH: mem_req; IRWrite&rdy; PCEn&rdy; ALU computes PC+4. On rdy go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, add. Next state by Opcode:
    - 000000 goes to EXEC, unless Funct is unknown, which goes to HALT with err 01.
    - 100011 and 101011 go to MEMADR.
    - 000100 and 000101 go to BRANCH.
    - 001000 goes to ADDIEX.
    - 000010 goes to JUMP.
    - Any other opcode goes to HALT with err 01.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, add. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req, IorD=1. On rdy go to MEMWB.
  - MEMWB: RegWrite, MemtoReg=1, RegDst=0. Go to FETCH.
  - MEMWR: mem_req, MemWrite, IorD=1. On rdy go to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Go to ALUWB.
  - ALUWB: RegWrite, RegDst=1, MemtoReg=0. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01. PCEn = ZeroFlag for beq, ~ZeroFlag for bne. Go to FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Go to ADDIWB.
  - ADDIWB: RegWrite, RegDst=0, MemtoReg=0. Go to FETCH.
  - JUMP: PCSrc=10, PCEn=1. Go to FETCH.
  - HALT: all strobes 0, mem_req 0, halted=1. Exit only by reset.
- Wait counter:
  - Clears on entry to any memory state and on every mem_ready.
  - Increments each cycle in FETCH/MEMRD/MEMWR while mem_ready=0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT while still not ready, go to HALT with err 10. That is TIMEOUT wait cycles allowed; ready on wait cycle TIMEOUT+1 is too late.
  - A mem_ready arriving in the same cycle the counter hits TIMEOUT wins: the access completes.
- Signals are don't-care where unspecified: Opcode/Funct outside DECODE/EXEC/BRANCH, and ZeroFlag outside BRANCH.
- err_code is written once, on entry to HALT, and is never overwritten.
- Instruction latency with zero wait states:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq/bne 3; j 3.
  - Each wait cycle adds 1.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - retired (CNT_W bits) increments by 1 on the cycle each instruction completes. Completion is the last state before FETCH: MEMWB, MEMWR&rdy, ALUWB, ADDIWB, BRANCH, JUMP.
  - Wraps modulo 2^CNT_W. Reset clears it to 0. It freezes in HALT.
- Undefined: the retired port and its logic are absent; all other behaviour is identical.

Test Plan:
- Zero-wait program add, sw, lw, beq (taken, ZeroFlag=1), mem_ready tied 1 -> state sequences exact; latencies 4/4/5/3; PCEn pulses once per FETCH plus once in BRANCH.
- bne with ZeroFlag=1 -> PCEn=0 in BRANCH; bne with ZeroFlag=0 -> PCEn=1; j -> PCSrc=10 and PCEn=1 for 1 cycle.
- Fetch with mem_ready low for 3 cycles, TIMEOUT=16 -> mem_req held 4 cycles; IRWrite and PCEn high only in cycle 4; fetch-to-DECODE takes 4 cycles.
- mem_ready never asserted in MEMRD, TIMEOUT=4 -> HALT after 4 wait cycles; err_code=10, halted=1, mem_req=0; mem_ready on wait cycle 4 instead -> completes normally.
- Opcode 111111 or R-type Funct 000111 -> HALT with err_code=01; assert rst mid-MEMWR -> MemWrite drops immediately, state FETCH, halted=0.
- PERF_CNT_EN, CNT_W=4, 17 back-to-back addi -> retired=1 after wrap; no change while halted.

Source files
------------

// File: rtl/mc_control_unit_hs.sv
// Handshaked multicycle MIPS control unit with memory wait timeout and illegal-instruction halt.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module mc_control_unit_hs #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             ZeroFlag,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             halted,
    output logic [1:0]       err_code
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Counter value seen during the last permitted wait cycle.
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    if (TO_W < 1 || CNT_W < 1 || (TIMEOUT != 0 && (2 ** TO_W) <= TIMEOUT)) begin : g_param_check
        $error("mc_control_unit_hs: TO_W/CNT_W too small for TIMEOUT");
    end

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_next;
    logic [1:0]      halt_err;
    logic            is_sw;
    logic            in_mem;
    logic            timeout_hit;

    // {valid, ALU control} for an R-type function field.
    function automatic logic [3:0] decode_funct(input logic [5:0] f);
        case (f)
            6'b100000: decode_funct = 4'b1_010;
            6'b100010: decode_funct = 4'b1_110;
            6'b100100: decode_funct = 4'b1_000;
            6'b100101: decode_funct = 4'b1_001;
            6'b101010: decode_funct = 4'b1_111;
            default:   decode_funct = 4'b0_000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            halted   <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state_next == S_HALT) begin
                halted <= 1'b1;
            end
            if (state_next == S_HALT && state != S_HALT) begin
                err_code <= halt_err;
            end
        end
    end

    // Opcode is only valid in DECODE, so remember lw/sw for MEMADR.
    always_ff @(posedge clk) begin
        if (state == S_DECODE) begin
            is_sw <= (Opcode == OP_SW);
        end
    end

    assign in_mem      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout_hit = (TIMEOUT != 0) && in_mem && !mem_ready && (wait_cnt == TO_LAST);
    assign wait_next   = (in_mem && !mem_ready) ? wait_cnt + TO_W'(1) : '0;

    always_comb begin
        state_next = state;
        halt_err   = ERR_ILLEGAL;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                    halt_err   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_next = decode_funct(Funct)[3] ? S_EXEC : S_HALT;
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_BEQ,OP_BNE: state_next = S_BRANCH;
                    OP_ADDI:       state_next = S_ADDIEX;
                    OP_J:          state_next = S_JUMP;
                    default:       state_next = S_HALT;
                endcase
            end
            S_MEMADR: state_next = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD, S_MEMWR: begin
                if (mem_ready) begin
                    state_next = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                    halt_err   = ERR_TIMEOUT;
                end
            end
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b010;
        PCSrc      = 2'b00;
        PCEn       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                IRWrite = mem_ready;
                PCEn    = mem_ready;
                ALUSrcB = 2'b01;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = decode_funct(Funct)[2:0];
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                PCSrc      = 2'b01;
                PCEn       = (Opcode == OP_BNE) ? ~ZeroFlag : ZeroFlag;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            S_HALT:   ALUControl = 3'b000;
            default:  ALUControl = 3'b000;
        endcase
    end

`ifdef PERF_CNT_EN
    logic retire;

    // An instruction retires in the last state before returning to FETCH.
    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_ADDIWB) ||
                    (state == S_BRANCH) || (state == S_JUMP) ||
                    (state == S_MEMWR && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_unit_hs.sv
// Directed bench for mc_control_unit_hs: per-cycle output patterns for each instruction class,
// wait states, timeout, illegal-instruction halt and asynchronous reset.
module tb_mc_control_unit_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       ZeroFlag;
    logic       mem_ready;
    logic       mem_req, MemWrite, IorD, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, PCEn, halted;
    logic [1:0] ALUSrcB, PCSrc, err_code;
    logic [2:0] ALUControl;
`ifdef PERF_CNT_EN
    logic [3:0] retired;
`endif

    int checks   = 0;
    int failures = 0;

    mc_control_unit_hs #(.TIMEOUT(4), .TO_W(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .ZeroFlag(ZeroFlag),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
        .PCEn(PCEn), .halted(halted), .err_code(err_code)
`ifdef PERF_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {mem_req, MemWrite, IorD, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB, ALUControl, PCSrc, PCEn, halted, err_code};

    localparam logic [18:0] M_STB  = (19'd1 << 18) | (19'd1 << 17) | (19'd1 << 15) | (19'd1 << 12) | 19'h0000F;
    localparam logic [18:0] M_IORD = 19'd1 << 16;
    localparam logic [18:0] M_WB   = (19'd1 << 14) | (19'd1 << 13);
    localparam logic [18:0] M_ALU  = 19'h00FC0;
    localparam logic [18:0] M_PCS  = 19'h00030;

    function automatic logic [18:0] ev(input logic mr, mw, iord, irw, m2r, rd, rw, asa,
                                       input logic [1:0] asb, input logic [2:0] alu,
                                       input logic [1:0] pcs, input logic pcen, hlt,
                                       input logic [1:0] err);
        return {mr, mw, iord, irw, m2r, rd, rw, asa, asb, alu, pcs, pcen, hlt, err};
    endfunction

    // Check the outputs of the current cycle, then advance to the next falling edge.
    task automatic step(input string tag, input logic [18:0] e, input logic [18:0] m);
        #1;
        checks++;
        assert ((obs & m) === (e & m))
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs & m, e & m);
        end
        @(negedge clk);
    endtask

    task automatic s_fetch(input string t, input logic rdy);
        mem_ready = rdy;
        step(t, ev(1,0,0,rdy,0,0,0,0,2'b01,3'b010,2'b00,rdy,0,2'b00), ~M_WB);
    endtask
    task automatic s_decode(input string t);
        step(t, ev(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,2'b00), M_STB | M_ALU);
    endtask
    task automatic s_memadr(input string t);
        step(t, ev(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,2'b00), M_STB | M_ALU);
    endtask
    task automatic s_memrd(input string t, input logic rdy);
        mem_ready = rdy;
        step(t, ev(1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,2'b00), M_STB | M_IORD);
    endtask
    task automatic s_memwb(input string t);
        step(t, ev(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,0,2'b00), M_STB | M_WB);
    endtask
    task automatic s_memwr(input string t, input logic rdy);
        mem_ready = rdy;
        step(t, ev(1,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,2'b00), M_STB | M_IORD);
    endtask
    task automatic s_exec(input string t, input logic [2:0] alu);
        step(t, ev(0,0,0,0,0,0,0,1,2'b00,alu,2'b00,0,0,2'b00), M_STB | M_ALU);
    endtask
    task automatic s_aluwb(input string t);
        step(t, ev(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0,2'b00), M_STB | M_WB);
    endtask
    task automatic s_branch(input string t, input logic pcen);
        step(t, ev(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,pcen,0,2'b00), M_STB | M_ALU | M_PCS);
    endtask
    task automatic s_addiwb(input string t);
        step(t, ev(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0,2'b00), M_STB | M_WB);
    endtask
    task automatic s_jump(input string t);
        step(t, ev(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0,2'b00), M_STB | M_PCS);
    endtask
    task automatic s_halt(input string t, input logic [1:0] err);
        step(t, ev(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1,err), M_STB);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        s_fetch("reset_state", 1'b0);
        rst = 1'b0;
    endtask

    logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alu_tab[5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

    initial begin
        rst = 1'b1; Opcode = 6'b0; Funct = 6'b0; ZeroFlag = 1'b0; mem_ready = 1'b0;
        do_reset();

        // Zero-wait program: add, sw, lw, beq taken.
        Opcode = 6'b000000; Funct = 6'b100000;
        s_fetch("add_fetch", 1); s_decode("add_decode"); s_exec("add_exec", 3'b010); s_aluwb("add_wb");
        Opcode = 6'b101011;
        s_fetch("sw_fetch", 1); s_decode("sw_decode"); s_memadr("sw_memadr"); s_memwr("sw_memwr", 1);
        Opcode = 6'b100011;
        s_fetch("lw_fetch", 1); s_decode("lw_decode"); s_memadr("lw_memadr");
        s_memrd("lw_memrd", 1); s_memwb("lw_memwb");
        Opcode = 6'b000100; ZeroFlag = 1'b1;
        s_fetch("beq_fetch", 1); s_decode("beq_decode"); s_branch("beq_taken", 1);
        ZeroFlag = 1'b0;
        s_fetch("beq_nt_fetch", 1); s_decode("beq_nt_decode"); s_branch("beq_not_taken", 0);

        // bne both ways, then jump.
        Opcode = 6'b000101; ZeroFlag = 1'b1;
        s_fetch("bne1_fetch", 1); s_decode("bne1_decode"); s_branch("bne_zero1", 0);
        ZeroFlag = 1'b0;
        s_fetch("bne0_fetch", 1); s_decode("bne0_decode"); s_branch("bne_zero0", 1);
        Opcode = 6'b000010;
        s_fetch("j_fetch", 1); s_decode("j_decode"); s_jump("j_jump");

        // All R-type functions and addi.
        for (int i = 0; i < 5; i++) begin
            Opcode = 6'b000000; Funct = fn_tab[i];
            s_fetch("rt_fetch", 1); s_decode("rt_decode"); s_exec("rt_exec", alu_tab[i]); s_aluwb("rt_wb");
        end
        Opcode = 6'b001000;
        s_fetch("addi_fetch", 1); s_decode("addi_decode"); s_memadr("addi_ex"); s_addiwb("addi_wb");

        // Fetch with three wait cycles, followed by a jump.
        Opcode = 6'b000010;
        s_fetch("wait_fetch1", 0); s_fetch("wait_fetch2", 0); s_fetch("wait_fetch3", 0);
        s_fetch("wait_fetch4", 1); s_decode("wait_decode"); s_jump("wait_jump");

        // lw with ready arriving on the last permitted wait cycle.
        Opcode = 6'b100011;
        s_fetch("late_fetch", 1); s_decode("late_decode"); s_memadr("late_memadr");
        s_memrd("late_rd1", 0); s_memrd("late_rd2", 0); s_memrd("late_rd3", 0);
        s_memrd("late_rd4", 1); s_memwb("late_memwb");

        // lw with ready never arriving: timeout halt, which is sticky.
        s_fetch("to_fetch", 1); s_decode("to_decode"); s_memadr("to_memadr");
        s_memrd("to_rd1", 0); s_memrd("to_rd2", 0); s_memrd("to_rd3", 0); s_memrd("to_rd4", 0);
        mem_ready = 1'b1; Opcode = 6'b000000;
        s_halt("to_halt1", 2'b10); s_halt("to_halt2", 2'b10);

        // Illegal opcode, then unknown R-type function.
        do_reset();
        Opcode = 6'b111111;
        s_fetch("ill_op_fetch", 1); s_decode("ill_op_decode"); s_halt("ill_op_halt", 2'b01);
        Opcode = 6'b000010;
        s_halt("ill_op_stays", 2'b01);
        do_reset();
        Opcode = 6'b000000; Funct = 6'b000111;
        s_fetch("ill_fn_fetch", 1); s_decode("ill_fn_decode"); s_halt("ill_fn_halt", 2'b01);

        // Asynchronous reset in the middle of a stalled store.
        do_reset();
        Opcode = 6'b101011;
        s_fetch("rsw_fetch", 1); s_decode("rsw_decode"); s_memadr("rsw_memadr");
        s_memwr("rsw_memwr", 0);
        rst = 1'b1;
        s_fetch("rst_mid_memwr", 0);
        rst = 1'b0;
        s_fetch("after_rst_fetch", 1);

`ifdef PERF_CNT_EN
        do_reset();
        checks++;
        assert (retired === 4'd0) else begin
            failures++; $error("FAIL retired_reset observed=%0d expected=0", retired);
        end
        Opcode = 6'b001000; mem_ready = 1'b1;
        repeat (17) repeat (4) @(negedge clk);
        #1;
        checks++;
        assert (retired === 4'd1) else begin
            failures++; $error("FAIL retired_wrap observed=%0d expected=1", retired);
        end
        Opcode = 6'b111111;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        assert (halted === 1'b1 && retired === 4'd1) else begin
            failures++; $error("FAIL retired_halt observed=%0d/%b expected=1/1", retired, halted);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
